addsub_signmag_pipe: RTL and testbench
======================================

ADDSUB_SIGNMAG_PIPE -- requirements
Module: addsub_signmag_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter CNT_W, default 16, width of the completed-operation counter.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port in_valid  input  1  operand set a/b/mode is presented.
REQ-006 Port in_ready  output  1  block accepts the operand set this cycle.
REQ-007 Port a  input  WIDTH  unsigned minuend/addend.
REQ-008 Port b  input  WIDTH  unsigned subtrahend/addend.
REQ-009 Port mode  input  1  0 = subtract (sign-magnitude |a-b|), 1 = add.
REQ-010 Port out_valid  output  1  result fields are valid.
REQ-011 Port out_ready  input  1  consumer takes the result this cycle.
REQ-012 Port s  output  WIDTH  result magnitude (sub) or truncated sum (add).
REQ-013 Port sign  output  1  1 = negative result (sub only).
REQ-014 Port carry  output  1  add overflow: bit WIDTH of a+b (sub: always 0).
REQ-015 Port zero  output  1  1 when s == 0.
REQ-016 Port op_count  output  CNT_W  number of results consumed since reset.

Function
REQ-017 A transfer SHALL occur on the input when in_valid & in_ready, and on the output when out_valid & out_ready, both sampled at the rising edge.
REQ-018 Stage 1 SHALL register mode and raw = a + (mode ? b : ~b) + (mode ? 0 : 1) computed at WIDTH+1 bits, keeping bit WIDTH as c1.
REQ-019 Stage 2 SHALL register: sub with c1=0 -> s = two's-complement negation of raw[WIDTH-1:0], sign=1; sub with c1=1 -> s = raw[WIDTH-1:0], sign=0; add -> s = raw[WIDTH-1:0], carry=c1, sign=0.
REQ-020 Sub with a == b SHALL give s=0, sign=0, zero=1 (no negative zero).
REQ-021 Latency SHALL be exactly 2 cycles from input transfer to out_valid with out_ready held high; throughput one operation per cycle.
REQ-022 Stage 2 SHALL advance when it is empty or its result is consumed that cycle; stage 1 SHALL advance when it is empty or stage 2 advances; in_ready SHALL equal the stage 1 advance condition (combinational from out_ready).
REQ-023 While out_valid=1 and out_ready=0, s, sign, carry, zero SHALL remain stable and no accepted operation SHALL be lost or reordered.
REQ-024 The pipeline SHALL hold at most 2 operations; with out_ready low, in_ready SHALL deassert once both stages are full.
REQ-025 Simultaneous output consume and input accept when full SHALL shift both stages in the same cycle with no bubble.
REQ-026 op_count SHALL increment by 1 on each output transfer and wrap from 2^CNT_W-1 to 0.
REQ-027 Stage data registers SHALL load only when their stage advances with valid data; invalid slots SHALL not affect outputs.

Reset
REQ-028 On rst_n low, asynchronously: both stage valid flags, out_valid, s, sign, carry, zero-source data and op_count SHALL clear to 0; zero output then reads 1 but is qualified by out_valid.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight operations; first input transfer after release yields out_valid 2 cycles later.
REQ-030 in_ready SHALL be 1 during and immediately after reset while out_ready is irrelevant (pipeline empty).

Verification (WIDTH=8)
REQ-031 mode=0, a=5, b=9, out_ready=1 -> 2 cycles later s=4, sign=1, zero=0, carry=0.
REQ-032 mode=0, a=200, b=200 -> s=0, sign=0, zero=1; mode=0, a=0, b=255 -> s=255, sign=1.
REQ-033 mode=1, a=200, b=100 -> s=44, carry=1, sign=0; a=100, b=27 -> s=127, carry=0.
REQ-034 Back-to-back ops (9-5, 3-7, 10+10) with out_ready=0 for 4 cycles -> in_ready drops after 2 accepted, s=4 sign=0 held stable; releasing out_ready yields 4/+, 4/-, 20 in order, one per cycle, op_count=3.
REQ-035 rst_n pulsed low with both stages full -> out_valid=0 and op_count=0 immediately, no stale result emitted after release.
REQ-036 CNT_W=4, 17 consumed results -> op_count=1 (wrap).

Source files
------------

// File: rtl/addsub_signmag_pipe.sv
// Two-stage pipelined unsigned add / sign-magnitude subtract with valid/ready
// handshaking on both sides and a wrapping count of consumed results.
module addsub_signmag_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             sign,
    output logic             carry,
    output logic             zero,
    output logic [CNT_W-1:0] op_count
);

    logic             v1;
    logic             v2;
    logic             mode1;
    logic [WIDTH:0]   raw1;
    logic [WIDTH:0]   raw_nx;
    logic [WIDTH-1:0] s_r;
    logic             sign_r;
    logic             carry_r;
    logic [CNT_W-1:0] cnt;
    logic             adv1;
    logic             adv2;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] neg_lo;
    logic [WIDTH-1:0] s_nx;
    logic             sign_nx;
    logic             carry_nx;

    // A full stage still advances when everything downstream moves this cycle.
    assign adv2     = !v2 || out_ready;
    assign adv1     = !v1 || adv2;
    assign in_ready = adv1;

    // Subtract as a + ~b + 1; bit WIDTH set means a >= b.
    assign raw_nx = {1'b0, a} + {1'b0, (mode ? b : ~b)} + {{WIDTH{1'b0}}, ~mode};

    assign lo     = raw1[WIDTH-1:0];
    assign neg_lo = '0 - lo;

    always_comb begin
        s_nx     = lo;
        sign_nx  = 1'b0;
        carry_nx = 1'b0;
        if (mode1) begin
            carry_nx = raw1[WIDTH];
        end else if (!raw1[WIDTH]) begin
            s_nx    = neg_lo;
            sign_nx = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            mode1 <= 1'b0;
            raw1  <= '0;
        end else if (adv1) begin
            v1 <= in_valid;
            if (in_valid) begin
                mode1 <= mode;
                raw1  <= raw_nx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2      <= 1'b0;
            s_r     <= '0;
            sign_r  <= 1'b0;
            carry_r <= 1'b0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                s_r     <= s_nx;
                sign_r  <= sign_nx;
                carry_r <= carry_nx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (v2 && out_ready) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign out_valid = v2;
    assign s         = s_r;
    assign sign      = sign_r;
    assign carry     = carry_r;
    assign zero      = (s_r == '0);
    assign op_count  = cnt;

endmodule

// File: tb/tb_addsub_signmag_pipe.sv
// Bench for addsub_signmag_pipe: a queue-based reference model of the
// two-slot pipeline plus directed literal cases, random traffic and resets.
module tb_addsub_signmag_pipe;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          mode;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  s;
    logic          sign;
    logic          carry;
    logic          zero;
    logic [CW-1:0] op_count;

    addsub_signmag_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .sign(sign), .carry(carry), .zero(zero),
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int s;
        int sign;
        int carry;
        int zero;
        int t;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   consumed = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic exp_t model(int x, int y, int m);
        exp_t e;
        int   d;
        if (m != 0) begin
            d       = x + y;
            e.s     = d % (1 << W);
            e.carry = (d >= (1 << W)) ? 1 : 0;
            e.sign  = 0;
        end else begin
            d       = x - y;
            e.s     = (d < 0) ? -d : d;
            e.sign  = (d < 0) ? 1 : 0;
            e.carry = 0;
        end
        e.zero = (e.s == 0) ? 1 : 0;
        e.t    = 0;
        return e;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at a negedge with inputs set; compares, then advances one clock.
    task automatic tick();
        bit   exp_ir;
        bit   exp_ov;
        bit   acc;
        bit   cons;
        exp_t e;
        #1;
        exp_ir = (q.size() < 2) || out_ready;
        exp_ov = (q.size() > 0) && ((cyc - q[0].t) >= 1);
        chk("in_ready", in_ready, exp_ir);
        chk("out_valid", out_valid, exp_ov);
        chk("op_count", op_count, consumed % (1 << CW));
        if (exp_ov && out_valid) begin
            chk("s", s, q[0].s);
            chk("sign", sign, q[0].sign);
            chk("carry", carry, q[0].carry);
            chk("zero", zero, q[0].zero);
        end
        acc  = in_valid && exp_ir;
        cons = exp_ov && out_ready;
        e    = model(int'(a), int'(b), int'(mode));
        @(posedge clk);
        cyc++;
        if (cons) begin
            void'(q.pop_front());
            consumed++;
        end
        if (acc) begin
            e.t = cyc;
            q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        rst_n     = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_zero", zero, 1);
        chk("rst_s", s, 0);
        q.delete();
        consumed = 0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        chk("rst_in_ready_hold", in_ready, 1);
        chk("rst_out_valid_hold", out_valid, 0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
    endtask

    task automatic lit_op(input int x, input int y, input int m,
                          input int es, input int esg, input int ec, input int ez);
        a = W'(x); b = W'(y); mode = m[0];
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("lit_valid", out_valid, 1);
        chk("lit_s", s, es);
        chk("lit_sign", sign, esg);
        chk("lit_carry", carry, ec);
        chk("lit_zero", zero, ez);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; mode = 1'b0;
        @(negedge clk);
        do_reset();

        lit_op(5, 9, 0, 4, 1, 0, 0);
        lit_op(200, 200, 0, 0, 0, 0, 1);
        lit_op(0, 255, 0, 255, 1, 0, 0);
        lit_op(200, 100, 1, 44, 0, 1, 0);
        lit_op(100, 27, 1, 127, 0, 0, 0);

        // Stall with two in flight, then drain in order.
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        a = 8'd9; b = 8'd5; mode = 1'b0; tick();
        a = 8'd3; b = 8'd7; mode = 1'b0; tick();
        a = 8'd10; b = 8'd10; mode = 1'b1;
        chk("stall_in_ready", in_ready, 0);
        chk("stall_s", s, 4);
        chk("stall_sign", sign, 0);
        tick(); tick();
        chk("stall_s_held", s, 4);
        chk("stall_sign_held", sign, 0);
        out_ready = 1'b1;
        chk("drain0_s", s, 4);
        chk("drain0_sign", sign, 0);
        tick();
        in_valid = 1'b0;
        chk("drain1_s", s, 4);
        chk("drain1_sign", sign, 1);
        tick();
        chk("drain2_s", s, 20);
        chk("drain2_carry", carry, 0);
        tick();
        chk("drain_count", op_count, 3);
        chk("drain_empty", out_valid, 0);

        // Reset with both stages full discards everything.
        out_ready = 1'b0; in_valid = 1'b1;
        a = 8'd1; b = 8'd2; mode = 1'b1; tick();
        a = 8'd3; b = 8'd4; mode = 1'b1; tick();
        do_reset();
        out_ready = 1'b1;
        repeat (3) tick();

        // Counter wrap: 17 results on a 4-bit counter.
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            a = W'($urandom_range(0, 255)); b = W'($urandom_range(0, 255));
            mode = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid = 1'b0;
        tick(); tick();
        chk("wrap_count", op_count, 1);

        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            a    = W'($urandom_range(0, 255));
            b    = ($urandom_range(0, 7) == 0) ? a : W'($urandom_range(0, 255));
            mode = 1'($urandom_range(0, 1));
            if (i == 1500) do_reset();
            else tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
